// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives imem, loads IF/ID with bubbles on stall and redirect.
// Define IF_PERF_CNT_EN to add the stall_cycles_o / fetch_count_o performance counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_enable_i,
  input  logic        ifid_enable_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic [31:0] ifid_instr_o,
  output logic [31:0] ifid_pc_o,
  output logic        ifid_valid_o,
  output logic [1:0]  fetch_state_o,
`ifdef IF_PERF_CNT_EN
  output logic [31:0] stall_cycles_o,
  output logic [31:0] fetch_count_o,
`endif
  output logic        misalign_err_o
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_e;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  ifid_instr_q, ifid_instr_d;
  logic [31:0]  ifid_pc_q, ifid_pc_d;
  logic         ifid_valid_q, ifid_valid_d;
  logic         misalign_q, misalign_d;

  assign imem_addr_o = pc_q;
  assign instr_o     = imem_rdata_i;

  // A redirect beats a stall: the target is loaded even with pc_enable low.
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid_i) begin
      pc_d = {redirect_pc_i[31:2], 2'b00};
    end else if (pc_enable_i) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_comb begin
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_valid_d = ifid_valid_q;
    if (redirect_valid_i) begin
      ifid_instr_d = NOP_INSTR;
      ifid_pc_d    = pc_q;
      ifid_valid_d = 1'b0;
    end else if (ifid_enable_i) begin
      ifid_pc_d = pc_q;
      if (pc_enable_i) begin
        ifid_instr_d = imem_rdata_i;
        ifid_valid_d = 1'b1;
      end else begin
        ifid_instr_d = NOP_INSTR;
        ifid_valid_d = 1'b0;
      end
    end
  end

  assign misalign_d = misalign_q | (redirect_valid_i & (redirect_pc_i[1:0] != 2'b00));

  always_comb begin
    state_d = state_q;
    if (redirect_valid_i) begin
      state_d = ST_FLUSH;
    end else begin
      case (state_q)
        ST_RUN:   if (!pc_enable_i) state_d = ST_HOLD;
        ST_HOLD:  if (pc_enable_i) state_d = ST_RUN;
        ST_FLUSH: state_d = pc_enable_i ? ST_RUN : ST_HOLD;
        default:  state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc_q    <= 32'd0;
      ifid_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      state_q      <= ST_RUN;
    end else begin
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_valid_q <= ifid_valid_d;
      misalign_q   <= misalign_d;
      state_q      <= state_d;
    end
  end

  assign ifid_instr_o   = ifid_instr_q;
  assign ifid_pc_o      = ifid_pc_q;
  assign ifid_valid_o   = ifid_valid_q;
  assign misalign_err_o = misalign_q;
  assign fetch_state_o  = state_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;

  // Counters wrap naturally at 2^32.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fetch_cnt_d = fetch_cnt_q;
    if (!pc_enable_i && !redirect_valid_i) stall_cnt_d = stall_cnt_q + 32'd1;
    if (ifid_enable_i && pc_enable_i && !redirect_valid_i) fetch_cnt_d = fetch_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
      fetch_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign stall_cycles_o = stall_cnt_q;
  assign fetch_count_o  = fetch_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized enables/redirects
// compared against a cycle-level reference model of the fetch rules.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pcEnable = 1'b0;
  logic        ifidEnable = 1'b0;
  logic        redirectValid = 1'b0;
  logic [31:0] redirectPc = 32'd0;
  logic [31:0] imemAddr, imemRdata, instr, ifidInstr, ifidPc;
  logic        ifidValid, misalignErr;
  logic [1:0]  fetchState;
`ifdef IF_PERF_CNT_EN
  logic [31:0] stallCycles, fetchCount;
`endif

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk              (clk),
    .rst              (rst),
    .pc_enable_i      (pcEnable),
    .ifid_enable_i    (ifidEnable),
    .redirect_valid_i (redirectValid),
    .redirect_pc_i    (redirectPc),
    .imem_addr_o      (imemAddr),
    .imem_rdata_i     (imemRdata),
    .instr_o          (instr),
    .ifid_instr_o     (ifidInstr),
    .ifid_pc_o        (ifidPc),
    .ifid_valid_o     (ifidValid),
    .fetch_state_o    (fetchState),
`ifdef IF_PERF_CNT_EN
    .stall_cycles_o   (stallCycles),
    .fetch_count_o    (fetchCount),
`endif
    .misalign_err_o   (misalignErr)
  );

  // Instruction memory returns a word derived from its address so every fetch is distinguishable.
  assign imemRdata = imemAddr + 32'h1000;

  always #5 clk = ~clk;

  logic [31:0] mPc, mIfidInstr, mIfidPc, mStall, mFetch;
  logic        mIfidValid, mErr;
  int          mState;
  int          checkCount = 0;
  int          passCount = 0;

  task automatic modelReset();
    mPc = RESET_PC; mIfidInstr = NOP; mIfidPc = 32'd0; mIfidValid = 1'b0;
    mState = 0; mErr = 1'b0; mStall = 32'd0; mFetch = 32'd0;
  endtask

  // One clock edge of the reference: the state register only reports what the last edge did.
  task automatic modelEdge();
    if (redirectValid) begin
      mIfidInstr = NOP; mIfidPc = mPc; mIfidValid = 1'b0;
    end else if (ifidEnable) begin
      mIfidPc = mPc;
      mIfidInstr = pcEnable ? (mPc + 32'h1000) : NOP;
      mIfidValid = pcEnable;
    end
    if (!pcEnable && !redirectValid) mStall = mStall + 1;
    if (ifidEnable && pcEnable && !redirectValid) mFetch = mFetch + 1;
    if (redirectValid && (redirectPc % 4 != 0)) mErr = 1'b1;
    mState = redirectValid ? 2 : (pcEnable ? 0 : 1);
    if (redirectValid) mPc = redirectPc - (redirectPc % 4);
    else if (pcEnable) mPc = mPc + 4;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
  endtask

  task automatic checkAll(input string phase);
    checkOutput({phase, " imem_addr"}, imemAddr, mPc);
    checkOutput({phase, " instr"}, instr, mPc + 32'h1000);
    checkOutput({phase, " ifid_instr"}, ifidInstr, mIfidInstr);
    checkOutput({phase, " ifid_pc"}, ifidPc, mIfidPc);
    checkOutput({phase, " ifid_valid"}, {31'd0, ifidValid}, {31'd0, mIfidValid});
    checkOutput({phase, " fetch_state"}, {30'd0, fetchState}, 32'(mState));
    checkOutput({phase, " misalign_err"}, {31'd0, misalignErr}, {31'd0, mErr});
`ifdef IF_PERF_CNT_EN
    checkOutput({phase, " stall_cycles"}, stallCycles, mStall);
    checkOutput({phase, " fetch_count"}, fetchCount, mFetch);
`endif
  endtask

  // Inputs change just after a falling edge; results are checked at the next falling edge.
  task automatic applyStimulus(input logic pe, input logic ie, input logic rv,
                               input logic [31:0] rp, input string phase);
    pcEnable = pe; ifidEnable = ie; redirectValid = rv; redirectPc = rp;
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkAll(phase);
  endtask

  initial begin
    modelReset();
    #1 rst = 1'b1;
    #2 checkAll("reset");
    checkOutput("reset imem_addr literal", imemAddr, 32'h100);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      checkOutput("run addr step", imemAddr, 32'h100 + 32'(4 * i));
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, "run");
      if (i < 2) begin
        checkOutput("run ifid_instr", ifidInstr, 32'h1100 + 32'(4 * i));
        checkOutput("run ifid_valid", {31'd0, ifidValid}, 32'd1);
      end
    end

    applyStimulus(1'b1, 1'b1, 1'b1, 32'h20, "goto 0x20");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, "stall");
      checkOutput("stall pc held", imemAddr, 32'h20);
      checkOutput("stall bubble", ifidInstr, NOP);
      checkOutput("stall valid", {31'd0, ifidValid}, 32'd0);
      checkOutput("stall state HOLD", {30'd0, fetchState}, 32'd1);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, "resume");
    checkOutput("resume state RUN", {30'd0, fetchState}, 32'd0);

    applyStimulus(1'b0, 1'b1, 1'b1, 32'h400, "redirect during stall");
    checkOutput("redirect addr", imemAddr, 32'h400);
    checkOutput("redirect bubble valid", {31'd0, ifidValid}, 32'd0);
    checkOutput("redirect state FLUSH", {30'd0, fetchState}, 32'd2);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, "after redirect");
    checkOutput("target ifid_pc", ifidPc, 32'h400);
    checkOutput("target ifid_instr", ifidInstr, 32'h1400);

    applyStimulus(1'b1, 1'b1, 1'b1, 32'h402, "misaligned redirect");
    checkOutput("misaligned addr", imemAddr, 32'h400);
    checkOutput("misaligned err", {31'd0, misalignErr}, 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, "err sticky");
    checkOutput("err persists", {31'd0, misalignErr}, 32'd1);

    applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, "goto top");
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, "wrap");
    checkOutput("pc wrap", imemAddr, 32'h0);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] rp;
      rp = $urandom;
      if ($urandom_range(0, 3) != 0) rp[1:0] = 2'b00;
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 7) == 0, rp, "random");
    end

    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, "pre-reset fetch");
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, "pre-reset hold");
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, "pre-reset hold");
    #2 rst = 1'b1;
    modelReset();
    #1 checkAll("async reset");
    checkOutput("async reset ifid_valid", {31'd0, ifidValid}, 32'd0);
    checkOutput("async reset ifid_pc", ifidPc, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, "first fetch");
    checkOutput("first fetch ifid_pc", ifidPc, RESET_PC);
    checkOutput("first fetch ifid_instr", ifidInstr, 32'h1100);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the rv32i-pico pipeline. It consumes the stall enables from the hazard unit and the branch/jump redirect from EX, owns the PC register, drives the instruction-memory address, and loads the IF/ID pipeline register. When it is stalled it inserts NOP bubbles. When it is redirected it squashes the wrong-path instruction.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0).

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- pc_enable  in  1  from hazard unit; 1 = PC may advance.
- ifid_enable  in  1  from hazard unit; 1 = IF/ID may update.
- redirect_valid  in  1  from EX; taken branch or JAL this cycle.
- redirect_pc  in  32  target address, valid with redirect_valid.
- imem_addr  out  32  instruction-memory address (= PC).
- imem_rdata  in  32  combinational read data for imem_addr.
- instr  out  32  raw fetched word, fed to the hazard unit.
- ifid_instr  out  32  IF/ID instruction.
- ifid_pc  out  32  IF/ID PC.
- ifid_valid  out  1  1 = ifid_instr is a real instruction, 0 = bubble.
- fetch_state  out  2  FSM state: 0 RUN, 1 HOLD, 2 FLUSH.
- misalign_err  out  1  sticky; a redirect target had bits [1:0] != 0.

## Operation
- imem_addr = pc. instr = imem_rdata. Both are combinational.
- PC update has the following priority:
  1. redirect_valid: pc <= {redirect_pc[31:2], 2'b00}.
  2. pc_enable: pc <= pc + 4, wrapping modulo 2^32 (32'hFFFF_FFFC goes to 0).
  3. Otherwise pc holds.
- IF/ID update has the following priority:
  1. redirect_valid: ifid_instr <= NOP_INSTR, ifid_valid <= 0, ifid_pc <= pc.
  2. !ifid_enable: the register holds.
  3. ifid_enable && pc_enable: ifid_instr <= imem_rdata, ifid_pc <= pc, ifid_valid <= 1.
  4. ifid_enable && !pc_enable: bubble. ifid_instr <= NOP_INSTR, ifid_valid <= 0, ifid_pc <= pc.
- misalign_err is set when redirect_valid && redirect_pc[1:0] != 0. It clears only on rst.
- FSM transitions, evaluated at each edge:
  - Any state, redirect_valid: go to FLUSH.
  - RUN, !pc_enable: go to HOLD.
  - HOLD, pc_enable: go to RUN.
  - FLUSH: go to RUN if pc_enable, else to HOLD.
- FLUSH lasts exactly one cycle unless redirect_valid is asserted again.
- redirect_valid and pc_enable=0 in the same cycle: the redirect wins and the PC loads the target.

## Timing
- Reset values, applied immediately on rst rise:
  - pc = RESET_PC, so imem_addr = RESET_PC.
  - ifid_instr = NOP_INSTR, ifid_pc = 0, ifid_valid = 0.
  - fetch_state = RUN, misalign_err = 0.
  - Perf counters = 0.
- On rst deassertion, the first fetch of RESET_PC is latched into IF/ID at the first edge.
- Fetch latency: a word fetched at cycle N appears on ifid_* at cycle N+1.
- Redirect latency: redirect_valid at cycle N gives imem_addr = target at N+1 and the target instruction on ifid_* at N+2. Cycle N+1 shows a bubble.
- When pc_enable is low, imem_addr is stable and the same word is re-read each cycle.

## Configuration
- IF_PERF_CNT_EN defined: adds two ports, both cleared on rst.
  - stall_cycles out 32: increments on each edge with !pc_enable && !redirect_valid.
  - fetch_count out 32: increments on each edge with ifid_enable && pc_enable && !redirect_valid.
  - Both counters wrap at 2^32.
- IF_PERF_CNT_EN undefined: neither the ports nor the counter logic exist.

## Test plan
- Reset with RESET_PC=0x100, then 4 cycles with enables high and imem returning addr+0x1000:
  - imem_addr steps 0x100, 0x104, 0x108, 0x10C.
  - ifid_instr is 0x1100 then 0x1104, with ifid_valid=1.
- pc_enable=0 for 3 cycles at pc=0x20, ifid_enable=1:
  - pc stays 0x20.
  - Three NOP bubbles with ifid_valid=0.
  - fetch_state=HOLD, then RUN after pc_enable returns.
- redirect_valid with redirect_pc=0x400 while pc_enable=0:
  - Next cycle imem_addr=0x400, ifid_valid=0, fetch_state=FLUSH.
  - The following cycle ifid_pc=0x400.
- redirect_pc=0x402: imem_addr=0x400 and misalign_err=1, which persists until rst.
- pc=0xFFFF_FFFC, pc_enable=1: next imem_addr=0x0000_0000.
- Assert rst mid-stall with ifid holding valid data:
  - All outputs take their reset values asynchronously, before the next edge.
  - With IF_PERF_CNT_EN defined, stall_cycles=0.
